// File: rtl/pipe_skid_reg.sv
// Pipeline-stage register with a 2-entry skid buffer, flush-to-bubble and
// saturating stall/flush counters. in_ready comes straight from a flop.
module pipe_skid_reg #(
    parameter int DATA_WIDTH = 32,
    parameter int CTRL_WIDTH = 16,
    parameter int CNT_WIDTH  = 16,
    parameter bit FLUSH_DATA = 1'b0
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [1:0]            occupancy,
    output logic [CNT_WIDTH-1:0]  stall_cnt,
    output logic [CNT_WIDTH-1:0]  flush_cnt
);

    // Handshake: a beat moves when valid and ready are both high at a rising
    // edge. in_valid never waits on in_ready; in_ready = !skid_valid, from a flop.
    // The state encoding equals the number of entries held, so it doubles as
    // the occupancy output.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic                  in_ready_q;
    logic [CTRL_WIDTH-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_WIDTH-1:0] main_data_q, main_data_d;
    logic [CTRL_WIDTH-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
    logic [CNT_WIDTH-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0]  flush_cnt_q, flush_cnt_d;

    logic main_valid;
    logic skid_valid;
    logic accept;
    logic drain;

    assign main_valid = (state_q != ST_EMPTY);
    assign skid_valid = (state_q == ST_FULL);
    assign accept     = in_valid & in_ready_q;
    assign drain      = main_valid & out_ready;

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != ST_FULL);
        end
    end

    // Next-state logic; flush overrides every transition
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: if (accept) state_d = ST_ONE;
                ST_ONE: begin
                    if (accept && !drain)      state_d = ST_FULL;
                    else if (!accept && drain) state_d = ST_EMPTY;
                end
                ST_FULL:  if (drain) state_d = ST_ONE;
                default:  state_d = ST_EMPTY;
            endcase
        end
    end

    // Entry and counter updates. Control bits are cleared whenever an entry
    // empties so out_ctrl reads 0 on every bubble.
    always_comb begin
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        if (flush) begin
            main_ctrl_d = '0;
            skid_ctrl_d = '0;
            if (FLUSH_DATA) begin
                main_data_d = '0;
                skid_data_d = '0;
            end
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                    end
                end
                ST_ONE: begin
                    if (accept && drain) begin
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                    end else if (accept) begin
                        skid_ctrl_d = in_ctrl;
                        skid_data_d = in_data;
                    end else if (drain) begin
                        main_ctrl_d = '0;
                    end
                end
                ST_FULL: begin
                    if (drain) begin
                        main_ctrl_d = skid_ctrl_q;
                        main_data_d = skid_data_q;
                        skid_ctrl_d = '0;
                    end
                end
                default: begin
                    main_ctrl_d = '0;
                    skid_ctrl_d = '0;
                end
            endcase
        end

        if (main_valid && !out_ready && (stall_cnt_q != {CNT_WIDTH{1'b1}}))
            stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
        if (flush && (main_valid || skid_valid) && (flush_cnt_q != {CNT_WIDTH{1'b1}}))
            flush_cnt_d = flush_cnt_q + CNT_WIDTH'(1);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            main_ctrl_q <= '0;
            main_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = main_valid;
    assign out_ctrl  = main_ctrl_q;
    assign out_data  = main_data_q;
    assign occupancy = state_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed bench for pipe_skid_reg: a default build plus a build with 4-bit
// counters and FLUSH_DATA=1, both driven by the same stimulus.
module tb_pipe_skid_reg;

    logic        clk;
    logic        rstn;
    logic        flush;
    logic        in_valid;
    logic [15:0] in_ctrl;
    logic [31:0] in_data;
    logic        out_ready;

    logic        in_ready,  s_in_ready;
    logic        out_valid, s_out_valid;
    logic [15:0] out_ctrl,  s_out_ctrl;
    logic [31:0] out_data,  s_out_data;
    logic [1:0]  occupancy, s_occupancy;
    logic [15:0] stall_cnt, flush_cnt;
    logic [3:0]  s_stall_cnt, s_flush_cnt;

    int          n_checks;
    int          n_errors;
    logic [31:0] exp_q[$];

    pipe_skid_reg dut (
        .clk(clk), .rstn(rstn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .occupancy(occupancy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipe_skid_reg #(.CNT_WIDTH(4), .FLUSH_DATA(1'b1)) dut_s (
        .clk(clk), .rstn(rstn), .flush(flush),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_ctrl(s_out_ctrl), .out_data(s_out_data),
        .occupancy(s_occupancy), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] c, input logic [31:0] d);
        in_valid = v;
        in_ctrl  = c;
        in_data  = d;
    endtask

    // Scoreboard: every delivered beat must be the oldest expected one
    always @(posedge clk) begin
        if (rstn && out_valid && out_ready) begin
            if (exp_q.size() == 0)
                check_eq("drain_unexpected", 64'(out_data), 64'(32'hFFFF_FFFF) ^ 64'(out_data));
            else
                check_eq("drain_order", 64'(out_data), 64'(exp_q.pop_front()));
        end
    end

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rstn      = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 16'h0, 32'h0);
        tick();
        tick();
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_in_ready",  64'(in_ready),  64'd1);
        check_eq("rst_out_ctrl",  64'(out_ctrl),  64'd0);
        check_eq("rst_out_data",  64'(out_data),  64'd0);
        check_eq("rst_occupancy", 64'(occupancy), 64'd0);
        check_eq("rst_stall",     64'(stall_cnt), 64'd0);
        check_eq("rst_flush",     64'(flush_cnt), 64'd0);
        rstn = 1'b1;
        tick();

        // 1: passthrough, 1-cycle latency
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 16'(i + 1), 32'h10 + 32'(i));
            exp_q.push_back(32'h10 + 32'(i));
            tick();
            check_eq("pt_in_ready",  64'(in_ready),  64'd1);
            check_eq("pt_out_valid", 64'(out_valid), 64'd1);
            check_eq("pt_out_data",  64'(out_data),  64'h10 + 64'(i));
            check_eq("pt_out_ctrl",  64'(out_ctrl),  64'(i + 1));
        end
        drive(1'b0, 16'h0, 32'h0);
        tick();
        check_eq("pt_idle_valid", 64'(out_valid), 64'd0);
        check_eq("pt_idle_ctrl",  64'(out_ctrl),  64'd0);
        check_eq("pt_idle_occ",   64'(occupancy), 64'd0);
        check_eq("pt_stall",      64'(stall_cnt), 64'd0);

        // 2: skid fill and release
        out_ready = 1'b0;
        drive(1'b1, 16'h00A, 32'hA0);
        exp_q.push_back(32'hA0);
        exp_q.push_back(32'hB0);
        tick();
        check_eq("sk_occ1", 64'(occupancy), 64'd1);
        drive(1'b1, 16'h00B, 32'hB0);
        tick();
        check_eq("sk_in_ready_full", 64'(in_ready),  64'd0);
        check_eq("sk_occ2",          64'(occupancy), 64'd2);
        check_eq("sk_head_data",     64'(out_data),  64'hA0);
        drive(1'b0, 16'h0, 32'h0);
        tick();
        check_eq("sk_stall2",  64'(stall_cnt), 64'd2);
        check_eq("sk_hold_occ", 64'(occupancy), 64'd2);
        out_ready = 1'b1;
        tick();
        check_eq("sk_second_data", 64'(out_data),  64'hB0);
        check_eq("sk_second_ctrl", 64'(out_ctrl),  64'h00B);
        check_eq("sk_occ_after",   64'(occupancy), 64'd1);
        check_eq("sk_in_ready",    64'(in_ready),  64'd1);
        tick();
        check_eq("sk_empty_valid", 64'(out_valid), 64'd0);
        check_eq("sk_q_drained",   64'(exp_q.size()), 64'd0);

        // 3: flush while FULL, with a beat offered on the flush cycle
        out_ready = 1'b0;
        drive(1'b1, 16'hFFFF, 32'hD0);
        tick();
        drive(1'b1, 16'hFFFF, 32'hE0);
        tick();
        check_eq("fl_pre_occ",  64'(occupancy), 64'd2);
        check_eq("fl_pre_ctrl", 64'(out_ctrl),  64'hFFFF);
        flush = 1'b1;
        drive(1'b1, 16'hFFFF, 32'hC0);
        tick();
        flush = 1'b0;
        drive(1'b0, 16'h0, 32'h0);
        check_eq("fl_out_valid", 64'(out_valid),   64'd0);
        check_eq("fl_out_ctrl",  64'(out_ctrl),    64'd0);
        check_eq("fl_occ",       64'(occupancy),   64'd0);
        check_eq("fl_in_ready",  64'(in_ready),    64'd1);
        check_eq("fl_cnt",       64'(flush_cnt),   64'd1);
        check_eq("fl_stall",     64'(stall_cnt),   64'd4);
        check_eq("fl_data_held", 64'(out_data),    64'hD0);
        check_eq("fl_data_zero", 64'(s_out_data),  64'd0);
        out_ready = 1'b1;
        tick();
        tick();
        check_eq("fl_no_c", 64'(out_valid), 64'd0);

        // 4: flush while empty, then FLUSH_DATA clearing
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_eq("fe_cnt_same", 64'(flush_cnt), 64'd1);
        check_eq("fe_occ",      64'(occupancy), 64'd0);
        out_ready = 1'b0;
        drive(1'b1, 16'h0001, 32'hDEADBEEF);
        tick();
        drive(1'b0, 16'h0, 32'h0);
        check_eq("fd_loaded", 64'(s_out_data), 64'hDEADBEEF);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_eq("fd_cleared",    64'(s_out_data), 64'd0);
        check_eq("fd_held",       64'(out_data),   64'hDEADBEEF);
        check_eq("fd_flush_cnt",  64'(flush_cnt),  64'd2);
        check_eq("fd_stall_cnt",  64'(stall_cnt),  64'd5);

        // 5: stall counter saturation on the 4-bit build
        drive(1'b1, 16'h0002, 32'h55);
        tick();
        drive(1'b0, 16'h0, 32'h0);
        for (int i = 0; i < 20; i++) tick();
        check_eq("sat_s_stall", 64'(s_stall_cnt), 64'd15);
        check_eq("sat_stall",   64'(stall_cnt),   64'd25);
        check_eq("sat_s_flush", 64'(s_flush_cnt), 64'd2);

        // 6: asynchronous reset between edges while FULL
        drive(1'b1, 16'h0003, 32'h66);
        tick();
        drive(1'b0, 16'h0, 32'h0);
        check_eq("ar_pre_occ", 64'(occupancy), 64'd2);
        #2 rstn = 1'b0;
        #1;
        check_eq("ar_out_valid", 64'(out_valid), 64'd0);
        check_eq("ar_in_ready",  64'(in_ready),  64'd1);
        check_eq("ar_occ",       64'(occupancy), 64'd0);
        check_eq("ar_out_ctrl",  64'(out_ctrl),  64'd0);
        check_eq("ar_out_data",  64'(out_data),  64'd0);
        check_eq("ar_stall",     64'(stall_cnt), 64'd0);
        check_eq("ar_flush",     64'(flush_cnt), 64'd0);
        #1 rstn = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 16'h0077, 32'h77);
        exp_q.push_back(32'h77);
        tick();
        drive(1'b0, 16'h0, 32'h0);
        check_eq("ar_first_valid", 64'(out_valid), 64'd1);
        check_eq("ar_first_data",  64'(out_data),  64'h77);
        tick();
        check_eq("ar_done_valid", 64'(out_valid),     64'd0);
        check_eq("ar_q_drained",  64'(exp_q.size()),  64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
